// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
//   - 2-bit direction counter encodings and the reset counter value
//   - bp_entry_t: one BTB entry (valid, tag, target, ctr)
//   - pc_index / pc_tag: PC field extraction shared by lookup and update
package bp_pkg;

   localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
   localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
   localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
   localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

   localparam logic [1:0] CTR_RST = CTR_WNT;

   // Widest tag occurs at the smallest table (4 entries -> 2 index bits).
   localparam int TAG_MAX_W = 28;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           ctr;
   } bp_entry_t;

   localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};

   // Index is pc[idx_w+1:2]; returned zero-extended to the 256-entry maximum.
   function automatic logic [7:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
      return 8'((pc >> 2) & ((32'd1 << idx_w) - 32'd1));
   endfunction

   // Tag is pc[31:idx_w+2]; narrower tags come back zero-extended.
   function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
      return TAG_MAX_W'(pc >> (idx_w + 32'd2));
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/train bundle between the IF/EX pipeline and the branch predictor.
//   master (pipeline side): drives fetch_pc, the upd_* resolution, bp_clear
//   slave  (predictor)    : drives pred_taken/pred_target, mispredict, counters
interface branch_predictor_if;

   logic        fetch_pc_dummy_unused_guard;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        bp_clear;
   logic        mispredict;
   logic [31:0] br_cnt;
   logic [31:0] mis_cnt;

   modport master (
      output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, bp_clear,
      input  pred_taken, pred_target, mispredict, br_cnt, mis_cnt
   );

   modport slave (
      input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, bp_clear,
      output pred_taken, pred_target, mispredict, br_cnt, mis_cnt
   );

endinterface

// File: rtl/branch_predictor_sat_ctr2.sv
// 2-bit saturating direction counter, next-state only.
//   ctr_i   : current counter value
//   taken_i : resolved direction (1 = count up)
//   ctr_o   : next counter value, saturating at CTR_SNT / CTR_ST
module sat_ctr2
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor feeding IF.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bp     : slave side of branch_predictor_if
//            lookup  fetch_pc -> pred_taken / pred_target (combinational)
//            train   upd_* from EX, bp_clear, mispredict flag
//            perf    br_cnt / mis_cnt saturating counters
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic               clk,
   input  logic               resetn,
   branch_predictor_if.slave  bp
);

   localparam int IDX_W = $clog2(ENTRIES);

   bp_entry_t tbl_q [ENTRIES];
   bp_entry_t tbl_d [ENTRIES];
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mis_cnt_q, mis_cnt_d;

   logic [IDX_W-1:0]     f_idx, u_idx;
   logic [TAG_MAX_W-1:0] f_tag, u_tag;
   logic                 f_hit, u_hit;
   logic [1:0]           ctr_nxt;
   logic                 mis;

   assign f_idx = IDX_W'(pc_index(bp.fetch_pc, IDX_W));
   assign f_tag = pc_tag(bp.fetch_pc, IDX_W);
   assign u_idx = IDX_W'(pc_index(bp.upd_pc, IDX_W));
   assign u_tag = pc_tag(bp.upd_pc, IDX_W);

   // Lookup reads registered state only, so an update this cycle is not visible yet.
   always_comb begin
      f_hit          = tbl_q[f_idx].valid && (tbl_q[f_idx].tag == f_tag);
      bp.pred_taken  = f_hit && tbl_q[f_idx].ctr[1];
      bp.pred_target = bp.pred_taken ? tbl_q[f_idx].target : bp.fetch_pc + 32'd4;
   end

   // A simultaneous clear wipes the entry first, so the update must see a miss.
   assign u_hit = tbl_q[u_idx].valid && (tbl_q[u_idx].tag == u_tag) && !bp.bp_clear;

   sat_ctr2 u_sat_ctr2 (
      .ctr_i   (tbl_q[u_idx].ctr),
      .taken_i (bp.upd_taken),
      .ctr_o   (ctr_nxt)
   );

   assign mis = bp.upd_valid &&
                ((bp.upd_taken != bp.upd_pred_taken) ||
                 (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
   assign bp.mispredict = mis;

   always_comb begin
      tbl_d = tbl_q;
      if (bp.bp_clear) begin
         for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
      end
      if (bp.upd_valid) begin
         if (u_hit) begin
            tbl_d[u_idx].ctr = ctr_nxt;
            if (bp.upd_taken) tbl_d[u_idx].target = bp.upd_target;
         end else if (bp.upd_taken) begin
            tbl_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: bp.upd_target, ctr: CTR_WT};
         end
      end
   end

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (bp.upd_valid && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d  = br_cnt_q + 32'd1;
      if (mis && (mis_cnt_q != 32'hFFFF_FFFF))         mis_cnt_d = mis_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= ENTRY_RST;
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign bp.br_cnt  = br_cnt_q;
   assign bp.mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   branch_predictor_if bif ();

   assign bif.fetch_pc_dummy_unused_guard = 1'b0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bp     (bif.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Start a new cycle just after the edge and present an update.
   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt, input logic clr);
      @(posedge clk); #1;
      bif.upd_valid       = 1'b1;
      bif.upd_pc          = pc;
      bif.upd_taken       = tk;
      bif.upd_target      = tgt;
      bif.upd_pred_taken  = ptk;
      bif.upd_pred_target = ptgt;
      bif.bp_clear        = clr;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      bif.upd_valid = 1'b0;
      bif.bp_clear  = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_tgt);
      bif.fetch_pc = pc;
      #1;
      chk({tag, "_tk"},  bif.pred_taken,  exp_tk);
      chk({tag, "_tgt"}, bif.pred_target, exp_tgt);
   endtask

   initial begin
      resetn              = 1'b0;
      bif.fetch_pc        = 32'h1C00_0000;
      bif.upd_valid       = 1'b0;
      bif.upd_pc          = '0;
      bif.upd_taken       = 1'b0;
      bif.upd_target      = '0;
      bif.upd_pred_taken  = 1'b0;
      bif.upd_pred_target = '0;
      bif.bp_clear        = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      look("rst_look", 32'h1C00_0000, 1'b0, 32'h1C00_0004);
      chk("rst_br", bif.br_cnt, 32'd0);
      chk("rst_mis", bif.mis_cnt, 32'd0);
      resetn = 1'b1;

      // Allocate; same-cycle lookup still sees the old (empty) entry
      upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("alloc_mis", bif.mispredict, 1'b1);
      look("same_cyc", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
      idle(); @(negedge clk);
      look("alloc_hit", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      chk("alloc_miscnt", bif.mis_cnt, 32'd1);
      chk("alloc_brcnt", bif.br_cnt, 32'd1);

      // Hysteresis: 10 -> 01
      upd(32'h1C00_0010, 1'b0, 32'h0, 1'b1, 32'h1C00_0100, 1'b0);
      @(negedge clk);
      chk("nt1_mis", bif.mispredict, 1'b1);
      idle(); @(negedge clk);
      look("ctr01", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
      // 01 -> 10 -> 11
      upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t1_mis", bif.mispredict, 1'b1);
      upd(32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b1, 32'h1C00_0100, 1'b0);
      @(negedge clk);
      chk("t2_mis", bif.mispredict, 1'b0);
      // 11 -> 10: still taken
      upd(32'h1C00_0010, 1'b0, 32'h0, 1'b1, 32'h1C00_0100, 1'b0);
      idle(); @(negedge clk);
      look("ctr10", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
      chk("hyst_br", bif.br_cnt, 32'd5);
      chk("hyst_mis", bif.mis_cnt, 32'd4);

      // Taken hit with new target: target mispredict, target overwritten
      upd(32'h1C00_0010, 1'b1, 32'h1C00_0200, 1'b1, 32'h1C00_0100, 1'b0);
      @(negedge clk);
      chk("tgt_mis", bif.mispredict, 1'b1);
      idle(); @(negedge clk);
      look("tgt_new", 32'h1C00_0010, 1'b1, 32'h1C00_0200);

      // Alias eviction: 0x1C000050 shares index 4
      upd(32'h1C00_0050, 1'b1, 32'h1C00_0300, 1'b0, 32'h0, 1'b0);
      idle(); @(negedge clk);
      look("evicted", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
      look("alias_hit", 32'h1C00_0050, 1'b1, 32'h1C00_0300);

      // Not-taken miss writes nothing
      upd(32'h1C00_0090, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("ntmiss_mis", bif.mispredict, 1'b0);
      idle(); @(negedge clk);
      look("ntmiss_keep", 32'h1C00_0050, 1'b1, 32'h1C00_0300);
      look("ntmiss_none", 32'h1C00_0090, 1'b0, 32'h1C00_0094);
      chk("ntmiss_br", bif.br_cnt, 32'd8);
      chk("ntmiss_miscnt", bif.mis_cnt, 32'd6);

      // Clear together with allocation
      upd(32'h1C00_0020, 1'b1, 32'h1C00_0400, 1'b0, 32'h0, 1'b1);
      idle(); @(negedge clk);
      look("clr_new", 32'h1C00_0020, 1'b1, 32'h1C00_0400);
      look("clr_old", 32'h1C00_0050, 1'b0, 32'h1C00_0054);
      chk("clr_br", bif.br_cnt, 32'd9);
      chk("clr_mis", bif.mis_cnt, 32'd7);

      // IF reset PC
      look("ifrst", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

      // Asynchronous reset mid-run with an update in flight
      bif.fetch_pc = 32'h1C00_0020;
      upd(32'h1C00_0030, 1'b1, 32'h1C00_0500, 1'b0, 32'h0, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk("arst_tk", bif.pred_taken, 1'b0);
      chk("arst_tgt", bif.pred_target, 32'h1C00_0024);
      chk("arst_br", bif.br_cnt, 32'd0);
      chk("arst_mis", bif.mis_cnt, 32'd0);
      @(posedge clk); #1;
      bif.upd_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      idle(); @(negedge clk);
      look("drop", 32'h1C00_0030, 1'b0, 32'h1C00_0034);

      // First update after release is accepted
      upd(32'h1C00_0030, 1'b1, 32'h1C00_0500, 1'b0, 32'h0, 1'b0);
      idle(); @(negedge clk);
      look("post_rst", 32'h1C00_0030, 1'b1, 32'h1C00_0500);
      chk("post_br", bif.br_cnt, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Next-PC predictor sitting directly upstream of the IF stage. It supplies the `pred_taken`/`pred_target` pair that IF muxes into its next-PC selection. It is a direct-mapped BTB with a 2-bit saturating direction counter per entry, looked up combinationally on the current fetch PC. It is trained by resolved branches returning from EX, and keeps branch/mispredict performance counters.

## Interface
- `ENTRIES`, 16: BTB entries; power of two, 4..256. `IDX_W = log2(ENTRIES)`, `TAG_W = 30 - IDX_W`.
- `clk` input 1: single clock; all state updates on rising edge.
- `resetn` input 1: **asynchronous, active-low** reset.
- `fetch_pc` input 32: PC currently held by IF.
- `pred_taken` output 1: predict taken for `fetch_pc`.
- `pred_target` output 32: predicted target; meaningful only when `pred_taken`=1.
- `upd_valid` input 1: one resolved branch/jump from EX this cycle.
- `upd_pc` input 32: PC of the resolved instruction.
- `upd_taken` input 1: actual direction.
- `upd_target` input 32: actual target; valid when `upd_taken`=1.
- `upd_pred_taken` input 1: prediction that was made for this instruction, carried down the pipe.
- `upd_pred_target` input 32: target that was predicted, carried down the pipe.
- `bp_clear` input 1: synchronous invalidate of all BTB entries.
- `mispredict` output 1: combinational flag for the current update.
- `br_cnt` output 32: count of updates.
- `mis_cnt` output 32: count of mispredicts.

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[31:IDX_W+2]`. `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag`, `target[31:0]`, and `ctr[1:0]`.
  - Counter encoding: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- **Lookup** (purely combinational from registered state):
  - `hit = valid[idx] && tag[idx] == fetch_tag`.
  - `pred_taken = hit && ctr[idx][1]`.
  - `pred_target = target[idx]` when `pred_taken`, else `fetch_pc + 4`.
- **Update**, when `upd_valid` is asserted:
  - Update hit:
    - `ctr` increments if taken, decrements if not taken; it saturates at 11 and 00.
    - If taken, `target` is overwritten with `upd_target`.
  - Update miss, taken: allocate the entry, overwriting any occupant: `valid`=1, `tag`, `target`=`upd_target`, `ctr`=10.
  - Update miss, not taken: no table write.
- `mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target))`.
- **Counters**:
  - `br_cnt` increments on every `upd_valid`.
  - `mis_cnt` increments when `mispredict` is asserted.
  - Both saturate at 32'hFFFFFFFF; there is no wrap.
- `bp_clear` clears every `valid` bit. Counters, tags and targets are kept.
  - When `bp_clear` and `upd_valid` occur together, the clear applies first, then a taken update allocates. The result is exactly one valid entry.
  - `br_cnt` and `mis_cnt` still count during a clear.

## Timing
- Lookup latency is 0 cycles: `pred_*` settle in the same cycle `fetch_pc` is presented.
- Update latency is 1 cycle: the write lands at the next rising edge, and a lookup of the same PC in the update cycle sees the old entry.
- Reset (async assert, `resetn`=0):
  - all `valid`=0, all `ctr`=01, `br_cnt`=`mis_cnt`=0;
  - tags and targets are don't-care (reset them to 0 for determinism);
  - outputs therefore give `pred_taken`=0 and `pred_target`=`fetch_pc`+4.
- Reset release is synchronous to `clk` edges. The first update is accepted on the first edge after `resetn` rises.
- Reset mid-operation: an update in flight during reset is dropped; no partial write.
- `fetch_pc` of 32'hFFFFFFFC (the IF reset value) must not assert `pred_taken` after reset. `pred_target` wraps to 0.
- There is no handshake; the block never stalls IF.

## Structure
- A shared package `bp_pkg` holds:
  - the counter encoding constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`;
  - the `bp_entry_t` struct (valid, tag, target, ctr);
  - the reset counter value.
- One sub-module, `sat_ctr2`: 2-bit saturating counter next-state logic (inputs current value and taken, output next value). It is instantiated once, on the update path.
- Index/tag extraction is shared between the lookup and update paths via common functions in `bp_pkg`.

## Test plan
- **Reset**: after reset, `fetch_pc`=0x1C000000 gives `pred_taken`=0 and `pred_target`=0x1C000004; `br_cnt`=`mis_cnt`=0.
- **Allocate and hit**:
  - Update pc=0x1C000010, taken, target 0x1C000100, pred_taken=0 → `mispredict`=1 and `mis_cnt`=1.
  - Next cycle, `fetch_pc`=0x1C000010 → `pred_taken`=1 and `pred_target`=0x1C000100.
- **Hysteresis**:
  - Starting from ctr=10, one not-taken update → ctr=01 and the lookup predicts not-taken.
  - Two taken updates → ctr=11.
  - One not-taken update → ctr=10, still predicting taken.
- **Alias eviction** (ENTRIES=16): PC 0x1C000010 allocated, then a taken update at 0x1C000050 (same index, different tag) → the lookup of 0x1C000010 misses.
- **Same-cycle write**: with the lookup and an allocating update on the same PC in one cycle, the lookup returns `pred_taken`=0 that cycle and 1 the next.
- **Clear and reset**:
  - `bp_clear` together with a taken update to 0x1C000020 → only 0x1C000020 hits afterwards.
  - `resetn` asserted mid-run → all outputs return to their reset values asynchronously, before the next edge.
